// File: rtl/hazard3_irq_sync_filter_pkg.sv
// Shared configuration for the IRQ synchroniser/filter: mode encoding and filter counter sizing.
// No latency or backpressure of its own; constants and helpers only.
package hazard3_irq_sync_filter_pkg;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

  localparam int NUM_IRQS_MAX      = 512;
  localparam int FILTER_CYCLES_MAX = 255;

  // Counter must represent 0..N-1; sized for 0..N so the width never collapses for N=1.
  function automatic int filt_cnt_w(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/hazard3_irq_sync_filter_if.sv
// Interrupt-line bundle between raw sources and the interrupt controller.
// No handshake: levels and single-cycle clear strobes, no backpressure.
interface hazard3_irq_sync_filter_if #(
  parameter int NUM_IRQS = 32
);

  logic [NUM_IRQS-1:0] irq_in;
  logic [NUM_IRQS-1:0] edge_mode;
  logic [NUM_IRQS-1:0] pend_clr;
  logic [NUM_IRQS-1:0] irq_out;
  logic                wakeup;

  modport master (
    output irq_in,
    output edge_mode,
    output pend_clr,
    input  irq_out,
    input  wakeup
  );

  modport slave (
    input  irq_in,
    input  edge_mode,
    input  pend_clr,
    output irq_out,
    output wakeup
  );

endinterface

// File: rtl/hazard3_irq_sync_filter_line.sv
// One IRQ line: synchroniser, glitch filter, rising-edge detect and sticky pend bit.
// Latency SYNC_STAGES+FILTER_CYCLES+1 edges (level) or +2 (edge); no backpressure.
module hazard3_irq_sync_filter_line
  import hazard3_irq_sync_filter_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic pend_clr,
  output logic irq_nxt,
  output logic irq_out
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic                   filt;
  logic                   filt_d;
  logic                   rise;
  logic                   pend;
  logic                   pend_nxt;

  // Dedicated flop chain so CDC constraints can target sync_chain/sync_ff alone.
  always_ff @(posedge clk or posedge rst) begin : sync_chain
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], irq_in};
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign filt = sync;
    end else begin : g_filter
      localparam int            CW       = filt_cnt_w(FILTER_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          filt_q;

      // Count only consecutive disagreeing cycles; any agreement restarts the window.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (sync != filt_q) begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            filt_q <= ~filt_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

  assign rise = filt & ~filt_d;

  always_comb begin
    pend_nxt = pend;
    if (edge_mode == MODE_LEVEL) begin
      pend_nxt = 1'b0;
    end else if (rise) begin
      pend_nxt = 1'b1;
    end else if (pend_clr) begin
      pend_nxt = 1'b0;
    end
    irq_nxt = (edge_mode == MODE_EDGE) ? pend : filt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_d  <= 1'b0;
      pend    <= 1'b0;
      irq_out <= 1'b0;
    end else begin
      filt_d  <= filt;
      pend    <= pend_nxt;
      irq_out <= irq_nxt;
    end
  end

endmodule

// File: rtl/hazard3_irq_sync_filter.sv
// NUM_IRQS independent sync/filter lines feeding the interrupt controller, plus a wakeup OR.
// Latency SYNC_STAGES+FILTER_CYCLES+1 (level) / +2 (edge) edges; no backpressure, pend held until pend_clr.
module hazard3_irq_sync_filter
  import hazard3_irq_sync_filter_pkg::*;
#(
  parameter int NUM_IRQS      = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  hazard3_irq_sync_filter_if.slave bus
);

  logic [NUM_IRQS-1:0] irq_nxt;
  logic [NUM_IRQS-1:0] irq_q;
  logic                wakeup_q;

  generate
    for (genvar i = 0; i < NUM_IRQS; i++) begin : g_line
      hazard3_irq_sync_filter_line #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
      ) u_line (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (bus.irq_in[i]),
        .edge_mode (bus.edge_mode[i]),
        .pend_clr  (bus.pend_clr[i]),
        .irq_nxt   (irq_nxt[i]),
        .irq_out   (irq_q[i])
      );
    end
  endgenerate

  // Built from the next-state so wakeup rises on the same edge as the first irq_out bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wakeup_q <= 1'b0;
    end else begin
      wakeup_q <= |irq_nxt;
    end
  end

  assign bus.irq_out = irq_q;
  assign bus.wakeup  = wakeup_q;

endmodule

// File: tb/tb_hazard3_irq_sync_filter.sv
// Bench: two instances (filter bypass and 4-cycle filter) driven identically, checked per cycle
// against a history-window reference model plus directed constant checks.
module tb_hazard3_irq_sync_filter;

  localparam int NI   = 32;
  localparam int SYNC = 2;
  localparam int NB   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NI-1:0] irq = '0;
  logic [NI-1:0] em  = '0;
  logic [NI-1:0] clr = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  hazard3_irq_sync_filter_if #(.NUM_IRQS(NI)) ifa ();
  hazard3_irq_sync_filter_if #(.NUM_IRQS(NI)) ifb ();

  assign ifa.irq_in    = irq;
  assign ifa.edge_mode = em;
  assign ifa.pend_clr  = clr;
  assign ifb.irq_in    = irq;
  assign ifb.edge_mode = em;
  assign ifb.pend_clr  = clr;

  hazard3_irq_sync_filter #(
    .NUM_IRQS(NI), .SYNC_STAGES(SYNC), .FILTER_CYCLES(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  hazard3_irq_sync_filter #(
    .NUM_IRQS(NI), .SYNC_STAGES(SYNC), .FILTER_CYCLES(NB)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // Reference model: index 0 = bypass instance, 1 = filtered instance.
  logic [NI-1:0] m_dl    [2][SYNC];
  logic [NI-1:0] m_filt  [2];
  logic [NI-1:0] m_filtd [2];
  logic [NI-1:0] m_pend  [2];
  logic [NI-1:0] m_irq   [2];
  logic          m_wake  [2];
  int            m_hist  [2][NI];
  int            m_since [2][NI];

  function automatic int flen(input int d);
    return (d == 0) ? 0 : NB;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < SYNC; k++) m_dl[d][k] = '0;
      m_filt[d]  = '0;
      m_filtd[d] = '0;
      m_pend[d]  = '0;
      m_irq[d]   = '0;
      m_wake[d]  = 1'b0;
      for (int l = 0; l < NI; l++) begin
        m_hist[d][l]  = 0;
        m_since[d][l] = 0;
      end
    end
  endfunction

  // filt flips once the last N synchronised samples, all taken since the previous flip, disagree with it.
  function automatic void model_edge(input int d);
    logic [NI-1:0] sync_o;
    logic [NI-1:0] filt_o;
    logic [NI-1:0] rise_o;
    int n;
    int mask;
    int win;
    n      = flen(d);
    sync_o = m_dl[d][SYNC-1];
    filt_o = (n == 0) ? sync_o : m_filt[d];
    rise_o = filt_o & ~m_filtd[d];
    for (int l = 0; l < NI; l++) begin
      m_irq[d][l] = em[l] ? m_pend[d][l] : filt_o[l];
      if (!em[l])          m_pend[d][l] = 1'b0;
      else if (rise_o[l])  m_pend[d][l] = 1'b1;
      else if (clr[l])     m_pend[d][l] = 1'b0;
    end
    m_filtd[d] = filt_o;
    for (int k = SYNC - 1; k > 0; k--) m_dl[d][k] = m_dl[d][k-1];
    m_dl[d][0] = irq;
    if (n == 0) begin
      m_filt[d] = m_dl[d][SYNC-1];
    end else begin
      mask = (1 << n) - 1;
      for (int l = 0; l < NI; l++) begin
        m_hist[d][l] = ((m_hist[d][l] << 1) | int'(sync_o[l])) & 255;
        if (m_since[d][l] < 1000) m_since[d][l]++;
        win = m_hist[d][l] & mask;
        if (m_since[d][l] >= n && (m_filt[d][l] ? (win == 0) : (win == mask))) begin
          m_filt[d][l]  = ~m_filt[d][l];
          m_since[d][l] = 0;
        end
      end
    end
    m_wake[d] = |m_irq[d];
  endfunction

  task automatic chk(input string tag, input logic [NI-1:0] got, input logic [NI-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    chk("a_irq_out_model", ifa.irq_out, m_irq[0]);
    chk_bit("a_wakeup_model", ifa.wakeup, m_wake[0]);
    chk("b_irq_out_model", ifb.irq_out, m_irq[1]);
    chk_bit("b_wakeup_model", ifb.wakeup, m_wake[1]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rst_assert();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_a_irq_out", ifa.irq_out, '0);
    chk_bit("rst_a_wakeup", ifa.wakeup, 1'b0);
    chk("rst_b_irq_out", ifb.irq_out, '0);
    chk_bit("rst_b_wakeup", ifb.wakeup, 1'b0);
  endtask

  task automatic rst_release();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_assert();
    ticks(2);
    rst_release();
    ticks(3);

    // Level mode, no filter: 3 edges each way on line 0.
    irq[0] = 1'b1;
    ticks(2);
    chk_bit("l0_rise_e2", ifa.irq_out[0], 1'b0);
    tick();
    chk_bit("l0_rise_e3", ifa.irq_out[0], 1'b1);
    chk_bit("l0_wakeup_e3", ifa.wakeup, 1'b1);
    irq[0] = 1'b0;
    ticks(2);
    chk_bit("l0_fall_e2", ifa.irq_out[0], 1'b1);
    tick();
    chk_bit("l0_fall_e3", ifa.irq_out[0], 1'b0);

    // Edge mode, 4-cycle filter: 3-cycle pulse rejected, 4-cycle pulse latched.
    em[5] = 1'b1;
    ticks(12);
    irq[5] = 1'b1;
    ticks(3);
    irq[5] = 1'b0;
    ticks(12);
    chk_bit("b_l5_short_rejected", ifb.irq_out[5], 1'b0);
    irq[5] = 1'b1;
    ticks(4);
    irq[5] = 1'b0;
    ticks(3);
    chk_bit("b_l5_e7", ifb.irq_out[5], 1'b0);
    tick();
    chk_bit("b_l5_e8", ifb.irq_out[5], 1'b1);
    ticks(10);
    chk_bit("b_l5_hold", ifb.irq_out[5], 1'b1);
    clr[5] = 1'b1;
    tick();
    clr[5] = 1'b0;
    tick();
    chk_bit("b_l5_cleared", ifb.irq_out[5], 1'b0);

    // Set and clear on the same edge: set wins.
    em[2] = 1'b1;
    irq[2] = 1'b1;
    ticks(6);
    irq[2] = 1'b0;
    ticks(15);
    chk_bit("b_l2_pend", ifb.irq_out[2], 1'b1);
    irq[2] = 1'b1;
    ticks(6);
    clr[2] = 1'b1;
    irq[2] = 1'b0;
    tick();
    clr[2] = 1'b0;
    tick();
    chk_bit("b_l2_set_wins_e1", ifb.irq_out[2], 1'b1);
    tick();
    chk_bit("b_l2_set_wins_e2", ifb.irq_out[2], 1'b1);
    ticks(10);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    ticks(2);
    chk_bit("b_l2_cleared", ifb.irq_out[2], 1'b0);

    // Mode switches on line 7.
    em[7] = 1'b1;
    irq[7] = 1'b1;
    ticks(6);
    irq[7] = 1'b0;
    ticks(15);
    chk_bit("b_l7_pend", ifb.irq_out[7], 1'b1);
    em[7] = 1'b0;
    ticks(2);
    chk_bit("b_l7_mode_off", ifb.irq_out[7], 1'b0);
    irq[7] = 1'b1;
    ticks(10);
    chk_bit("b_l7_level_high", ifb.irq_out[7], 1'b1);
    em[7] = 1'b1;
    ticks(8);
    chk_bit("b_l7_no_edge_from_level", ifb.irq_out[7], 1'b0);
    irq[7] = 1'b0;
    em[7]  = 1'b0;
    ticks(10);

    // Reset in the middle of a filter window.
    irq[1] = 1'b1;
    ticks(10);
    chk_bit("b_l1_level_high", ifb.irq_out[1], 1'b1);
    irq[9] = 1'b1;
    ticks(4);
    rst_assert();
    tick();
    rst_release();
    ticks(6);
    chk_bit("b_l9_restart_e6", ifb.irq_out[9], 1'b0);
    tick();
    chk_bit("b_l9_restart_e7", ifb.irq_out[9], 1'b1);

    // All lines high through reset release in edge mode.
    irq = '1;
    em  = '1;
    rst_assert();
    ticks(2);
    rst_release();
    ticks(3);
    chk("a_all_e3", ifa.irq_out, '0);
    chk_bit("a_wake_e3", ifa.wakeup, 1'b0);
    tick();
    chk("a_all_e4", ifa.irq_out, '1);
    chk_bit("a_wake_e4", ifa.wakeup, 1'b1);
    ticks(3);
    chk("b_all_e7", ifb.irq_out, '0);
    tick();
    chk("b_all_e8", ifb.irq_out, '1);
    chk_bit("b_wake_e8", ifb.wakeup, 1'b1);

    // Randomised traffic, occasional mode changes and resets.
    irq = '0;
    em  = '0;
    for (int c = 0; c < 600; c++) begin
      irq = irq ^ ($urandom & $urandom & $urandom);
      clr = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 39) == 0) em = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst_assert();
        tick();
        rst_release();
      end
      tick();
    end
    clr = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
